vm_txn_ctrl: RTL and testbench
==============================

// Module: vm_txn_ctrl
// PURPOSE
//  User-transaction controller for the vm2002 vending machine.
//  - Accumulates inserted coins into a credit balance.
//  - On a selection, looks up price and stock from the item/cost tables.
//  - Sequences vend, stock decrement and change return.
//  - Arbitrates the shared item/cost tables between the user and the supplier restock port.
// PARAMETERS
//  MAX_BALANCE  16'd1000  credit ceiling in cents; a coin that would exceed it is rejected
//  TIMEOUT      8'd200    idle cycles in COLLECT before automatic refund
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-low reset
//  coin_valid    in   1   one-cycle strobe: coin inserted
//  coin          in   2   coin code: 00=5c, 01=10c, 10=25c, 11=100c
//  sel_valid     in   1   one-cycle strobe: item button pressed
//  sel_item      in   3   selected item (vm2002 item encoding)
//  cancel        in   1   one-cycle strobe: user cancel
//  sup_req       in   1   supplier requests table access (level)
//  sup_gnt       out  1   supplier owns the tables (level)
//  price_item    out  3   item index driven to the cost/count tables
//  price         in   16  cost of price_item, combinational from table
//  stock         in   5   count of price_item, combinational from table (0..16)
//  dec_stock     out  1   one-cycle pulse: decrement count of product
//  product       out  3   item being vended, valid with vend
//  vend          out  1   one-cycle dispense pulse
//  coin_reject   out  1   one-cycle pulse: coin returned, not credited
//  status        out  2   0=OK, 1=SOLD_OUT, 2=LOW_CREDIT, 3=BUSY
//  balance       out  16  current credit in cents
//  change        out  16  refund amount, valid with change_valid
//  change_valid  out  1   one-cycle pulse: return change
// BEHAVIOUR
//  Reset (rst==0 at clk edge):
//   - state=IDLE; every output, balance, timer and latched item = 0.
//   - Reset mid-transaction discards credit; no change_valid is issued.
//  States: IDLE, COLLECT, LOOKUP, VEND, REFUND, SERVICE.
//  IDLE:
//   - sup_req=1 -> SERVICE. Priority over coin_valid; a same-cycle coin is rejected.
//   - else coin_valid -> COLLECT, balance=coin value.
//   - sel_valid -> status=LOW_CREDIT, stay in IDLE. cancel is ignored.
//  COLLECT:
//   - coin_valid adds the coin if balance+coin <= MAX_BALANCE; otherwise coin_reject=1 and balance is unchanged.
//   - cancel -> REFUND. cancel beats sel_valid; a same-cycle coin is credited before the refund.
//   - sel_valid -> LOOKUP; sel_item latched. A same-cycle coin is credited first.
//   - Timer clears on any coin/sel/cancel and on entry. Timer==TIMEOUT-1 -> REFUND.
//   - sup_req is not granted here; it waits for IDLE.
//  LOOKUP (1 cycle):
//   - price_item = latched item.
//   - stock==0 -> status=SOLD_OUT, back to COLLECT.
//   - else balance<price -> status=LOW_CREDIT, back to COLLECT.
//   - else status=OK -> VEND.
//   - Coins arriving in LOOKUP are credited under the COLLECT rules; the comparison uses the pre-coin balance.
//  VEND (1 cycle):
//   - vend=1, dec_stock=1, product=item; balance <= balance-price (16-bit, cannot underflow).
//   - Next state: REFUND if the remainder is >0, else IDLE.
//   - Coins in VEND/REFUND -> coin_reject.
//  REFUND (1 cycle): change=balance, change_valid=1, balance<=0 -> IDLE.
//  SERVICE:
//   - sup_gnt=1, status=BUSY.
//   - coin_valid -> coin_reject. sel/cancel ignored.
//   - sup_req=0 -> IDLE next cycle; sup_gnt drops in that same cycle.
//  Outputs:
//   - status holds until the next LOOKUP or SERVICE entry.
//   - All other outputs are registered; pulses last exactly one cycle.
//   - price_item holds the latched item outside LOOKUP.
//  Latency: sel_valid -> vend = 2 cycles; vend -> change_valid = 1 cycle.
// TESTING
//  1. Coins 25,25,25,25 then sel WATER (price 75, stock 3) -> vend=1 product=WATER dec_stock=1, then change=25 change_valid=1, IDLE.
//  2. Balance 10, sel COLA (price 50) -> status=LOW_CREDIT, balance 10 retained, back in COLLECT; add 100, sel -> vend, change=60.
//  3. Balance 100, sel CHIPS with stock 0 -> status=SOLD_OUT, no vend/dec_stock; cancel -> change=100, balance=0.
//  4. Balance 950, insert 100 -> coin_reject=1, balance stays 950; no activity for TIMEOUT cycles -> change=950.
//  5. sup_req and coin_valid in the same IDLE cycle -> sup_gnt=1, coin_reject=1, status=BUSY; sup_req in COLLECT -> no grant until the refund completes.
//  6. Balance 50, assert rst=0 for one cycle -> balance=0, no change_valid, IDLE; exact price 50 -> vend with no change_valid.

Source files
------------

// File: rtl/vm_txn_ctrl.sv
// vm2002 user-transaction controller: coin credit, selection lookup,
// vend/change sequencing and user/supplier arbitration of the item tables.
module vm_txn_ctrl #(
  parameter logic [15:0] MAX_BALANCE = 16'd1000,
  parameter logic [7:0]  TIMEOUT     = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_valid,
  input  logic [1:0]  coin,
  input  logic        sel_valid,
  input  logic [2:0]  sel_item,
  input  logic        cancel,
  input  logic        sup_req,
  output logic        sup_gnt,
  output logic [2:0]  price_item,
  input  logic [15:0] price,
  input  logic [4:0]  stock,
  output logic        dec_stock,
  output logic [2:0]  product,
  output logic        vend,
  output logic        coin_reject,
  output logic [1:0]  status,
  output logic [15:0] balance,
  output logic [15:0] change,
  output logic        change_valid
);

  localparam int unsigned BAL_W = 16;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_SOLD_OUT   = 2'd1;
  localparam logic [1:0] ST_LOW_CREDIT = 2'd2;
  localparam logic [1:0] ST_BUSY       = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    LOOKUP  = 3'd2,
    VEND    = 3'd3,
    REFUND  = 3'd4,
    SERVICE = 3'd5
  } state_t;

  state_t           state;
  logic [7:0]       timer;
  logic [BAL_W-1:0] coin_val_c;
  logic [BAL_W:0]   credit_sum_c;
  logic             coin_ok_c;
  logic [BAL_W-1:0] bal_credit_c;
  logic [BAL_W-1:0] remainder_c;

  // Coin value and the balance after crediting it under the ceiling rule
  always_comb begin
    coin_val_c = 16'd100;
    case (coin)
      2'b00:   coin_val_c = 16'd5;
      2'b01:   coin_val_c = 16'd10;
      2'b10:   coin_val_c = 16'd25;
      default: coin_val_c = 16'd100;
    endcase
    credit_sum_c = {1'b0, balance} + {1'b0, coin_val_c};
    coin_ok_c    = coin_valid && (credit_sum_c <= {1'b0, MAX_BALANCE});
    bal_credit_c = coin_ok_c ? credit_sum_c[BAL_W-1:0] : balance;
    remainder_c  = balance - price;
  end

  // price_item doubles as the latched selection so the tables are already
  // addressed by the time LOOKUP and VEND sample price/stock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= 8'd0;
      sup_gnt      <= 1'b0;
      price_item   <= 3'd0;
      dec_stock    <= 1'b0;
      product      <= 3'd0;
      vend         <= 1'b0;
      coin_reject  <= 1'b0;
      status       <= ST_OK;
      balance      <= '0;
      change       <= '0;
      change_valid <= 1'b0;
    end else begin
      vend         <= 1'b0;
      dec_stock    <= 1'b0;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sup_req) begin
            state       <= SERVICE;
            sup_gnt     <= 1'b1;
            status      <= ST_BUSY;
            coin_reject <= coin_valid;
          end else if (coin_valid) begin
            state   <= COLLECT;
            balance <= coin_val_c;
            timer   <= 8'd0;
          end else if (sel_valid) begin
            status <= ST_LOW_CREDIT;
          end
        end
        COLLECT: begin
          balance     <= bal_credit_c;
          coin_reject <= coin_valid && !coin_ok_c;
          if (cancel) begin
            state        <= REFUND;
            timer        <= 8'd0;
            change       <= bal_credit_c;
            change_valid <= 1'b1;
          end else if (sel_valid) begin
            state      <= LOOKUP;
            timer      <= 8'd0;
            price_item <= sel_item;
          end else if (coin_valid) begin
            timer <= 8'd0;
          end else if (timer == TIMEOUT - 8'd1) begin
            state        <= REFUND;
            timer        <= 8'd0;
            change       <= balance;
            change_valid <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        LOOKUP: begin
          // Decision uses the pre-coin balance; a coin here is still credited
          balance     <= bal_credit_c;
          coin_reject <= coin_valid && !coin_ok_c;
          timer       <= 8'd0;
          if (stock == 5'd0) begin
            state  <= COLLECT;
            status <= ST_SOLD_OUT;
          end else if (balance < price) begin
            state  <= COLLECT;
            status <= ST_LOW_CREDIT;
          end else begin
            state     <= VEND;
            status    <= ST_OK;
            vend      <= 1'b1;
            dec_stock <= 1'b1;
            product   <= price_item;
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          balance     <= remainder_c;
          if (remainder_c != '0) begin
            state        <= REFUND;
            change       <= remainder_c;
            change_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        REFUND: begin
          coin_reject <= coin_valid;
          balance     <= '0;
          state       <= IDLE;
        end
        SERVICE: begin
          coin_reject <= coin_valid;
          if (!sup_req) begin
            state   <= IDLE;
            sup_gnt <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_txn_ctrl.sv
// Bench for vm_txn_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vm_txn_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_valid, sel_valid, cancel, sup_req;
  logic [1:0]  coin;
  logic [2:0]  sel_item;
  logic        sup_gnt, dec_stock, vend, coin_reject, change_valid;
  logic [2:0]  price_item, product;
  logic [15:0] price, balance, change;
  logic [4:0]  stock;
  logic [1:0]  status;

  localparam logic [2:0] COLA  = 3'd1;
  localparam logic [2:0] WATER = 3'd2;
  localparam logic [2:0] CHIPS = 3'd4;

  // Item tables owned by the bench (index = item code)
  logic [15:0] tbl_price [8] = '{16'd100, 16'd50, 16'd75, 16'd65, 16'd60, 16'd45, 16'd35, 16'd125};
  logic [4:0]  tbl_stock [8] = '{5'd4, 5'd5, 5'd3, 5'd2, 5'd0, 5'd7, 5'd1, 5'd16};
  int          coin_cents [4] = '{5, 10, 25, 100};

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  int vend_cnt = 0;
  int chg_cnt = 0;

  vm_txn_ctrl dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .cancel(cancel), .sup_req(sup_req), .sup_gnt(sup_gnt),
    .price_item(price_item), .price(price), .stock(stock),
    .dec_stock(dec_stock), .product(product), .vend(vend),
    .coin_reject(coin_reject), .status(status), .balance(balance),
    .change(change), .change_valid(change_valid)
  );

  always #5 clk = ~clk;

  assign price = tbl_price[price_item];
  assign stock = tbl_stock[price_item];

  always @(posedge clk)
    if (rst && dec_stock) tbl_stock[product] <= tbl_stock[product] - 5'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Customer-level model: credit in cents, what the customer is doing, and
  // the outcome of a selection decided from the tables when it is pressed.
  localparam int M_IDLE = 0, M_SHOP = 1, M_CHECK = 2, M_DISPENSE = 3, M_PAYOUT = 4, M_SERVICE = 5;
  int mode = M_IDLE, credit = 0, quiet = 0, cost = 0, verdict = 0;
  logic [2:0] pick = 3'd0;
  int e_vend = 0, e_dec = 0, e_rej = 0, e_chg_v = 0, e_gnt = 0, e_status = 0;
  int e_item = 0, e_product = 0, e_change = 0, e_balance = 0;

  always @(posedge clk) begin : model
    int cv;
    bit fits;
    e_vend = 0; e_dec = 0; e_rej = 0; e_chg_v = 0;
    if (!rst) begin
      mode = M_IDLE; credit = 0; quiet = 0;
      e_gnt = 0; e_status = 0; e_item = 0; e_product = 0; e_change = 0;
    end else begin
      cv = coin_cents[coin];
      fits = coin_valid && (credit + cv <= 1000);
      case (mode)
        M_IDLE: begin
          if (sup_req) begin
            mode = M_SERVICE; e_gnt = 1; e_status = 3; e_rej = int'(coin_valid);
          end else if (coin_valid) begin
            mode = M_SHOP; credit = cv; quiet = 0;
          end else if (sel_valid) e_status = 2;
        end
        M_SHOP, M_CHECK: begin
          if (fits) credit += cv;
          e_rej = int'(coin_valid && !fits);
          if (mode == M_CHECK) begin
            e_status = verdict;
            quiet = 0;
            if (verdict == 0) begin
              mode = M_DISPENSE; e_vend = 1; e_dec = 1; e_product = int'(pick);
            end else mode = M_SHOP;
          end else if (cancel) begin
            e_change = credit; e_chg_v = 1; mode = M_PAYOUT;
          end else if (sel_valid) begin
            pick = sel_item; e_item = int'(sel_item);
            cost = int'(tbl_price[sel_item]);
            if (tbl_stock[sel_item] == 5'd0) verdict = 1;
            else if (credit < cost) verdict = 2;
            else verdict = 0;
            mode = M_CHECK;
          end else if (coin_valid) quiet = 0;
          else begin
            quiet++;
            if (quiet == 200) begin e_change = credit; e_chg_v = 1; mode = M_PAYOUT; end
          end
        end
        M_DISPENSE: begin
          e_rej = int'(coin_valid);
          credit -= cost;
          if (credit > 0) begin e_change = credit; e_chg_v = 1; mode = M_PAYOUT; end
          else mode = M_IDLE;
        end
        M_PAYOUT: begin
          e_rej = int'(coin_valid); credit = 0; mode = M_IDLE;
        end
        default: begin
          e_rej = int'(coin_valid);
          if (!sup_req) begin mode = M_IDLE; e_gnt = 0; end
        end
      endcase
    end
    e_balance = credit;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("vend", 32'(vend), e_vend);
      chk("dec_stock", 32'(dec_stock), e_dec);
      chk("coin_reject", 32'(coin_reject), e_rej);
      chk("change_valid", 32'(change_valid), e_chg_v);
      chk("sup_gnt", 32'(sup_gnt), e_gnt);
      chk("status", 32'(status), e_status);
      chk("balance", 32'(balance), e_balance);
      chk("price_item", 32'(price_item), e_item);
      if (e_vend != 0) chk("product", 32'(product), e_product);
      if (e_chg_v != 0) chk("change", 32'(change), e_change);
      if (vend) vend_cnt++;
      if (change_valid) chg_cnt++;
    end
  end

  task automatic coin_in(input logic [1:0] c);
    coin_valid = 1'b1; coin = c;
    @(negedge clk);
    coin_valid = 1'b0;
  endtask

  task automatic sel_in(input logic [2:0] it);
    sel_valid = 1'b1; sel_item = it;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic cancel_in();
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vend(input logic [2:0] it, input int budget);
    int i = 0;
    while (!vend && i < budget) begin @(negedge clk); i++; end
    chk("vend_seen", 32'(vend), 1);
    if (vend) begin
      chk("vend_product", 32'(product), 32'(it));
      chk("vend_dec_stock", 32'(dec_stock), 1);
    end
  endtask

  task automatic wait_change(input int exp, input int budget);
    int i = 0;
    while (!change_valid && i < budget) begin @(negedge clk); i++; end
    chk("change_seen", 32'(change_valid), 1);
    if (change_valid) chk("change_amount", 32'(change), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int v0, c0;
    rst = 1'b0; coin_valid = 1'b0; coin = 2'd0; sel_valid = 1'b0;
    sel_item = 3'd0; cancel = 1'b0; sup_req = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_balance", 32'(balance), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_sup_gnt", 32'(sup_gnt), 0);
    chk("rst_vend", 32'(vend), 0);
    chk("rst_change_valid", 32'(change_valid), 0);
    chk("rst_price_item", 32'(price_item), 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: four quarters, WATER at 75 -> vend and 25 back
    repeat (4) coin_in(2'd2);
    chk("t1_balance", 32'(balance), 100);
    sel_in(WATER);
    wait_vend(WATER, 4);
    wait_change(25, 3);
    idle(2);
    chk("t1_balance_end", 32'(balance), 0);

    // 2: 10c short of COLA, then top up with 100
    coin_in(2'd1);
    sel_in(COLA);
    idle(2);
    chk("t2_status", 32'(status), 2);
    chk("t2_balance", 32'(balance), 10);
    coin_in(2'd3);
    sel_in(COLA);
    wait_vend(COLA, 4);
    wait_change(60, 3);
    idle(2);

    // 3: sold-out CHIPS, then cancel
    coin_in(2'd3);
    sel_in(CHIPS);
    v0 = vend_cnt;
    idle(3);
    chk("t3_status", 32'(status), 1);
    chk("t3_no_vend", 32'(vend_cnt), 32'(v0));
    cancel_in();
    wait_change(100, 3);
    idle(2);
    chk("t3_balance_end", 32'(balance), 0);

    // 4: ceiling reject at 950, then idle timeout refund
    repeat (9) coin_in(2'd3);
    repeat (2) coin_in(2'd2);
    chk("t4_balance", 32'(balance), 950);
    coin_in(2'd3);
    chk("t4_reject", 32'(coin_reject), 1);
    chk("t4_balance_kept", 32'(balance), 950);
    wait_change(950, 220);
    idle(2);

    // 5: supplier vs coin in IDLE, then request deferred during COLLECT
    sup_req = 1'b1;
    coin_in(2'd2);
    chk("t5_gnt", 32'(sup_gnt), 1);
    chk("t5_reject", 32'(coin_reject), 1);
    chk("t5_status", 32'(status), 3);
    idle(3);
    sup_req = 1'b0;
    @(negedge clk);
    chk("t5_gnt_drop", 32'(sup_gnt), 0);
    coin_in(2'd2);
    sup_req = 1'b1;
    idle(3);
    chk("t5_no_gnt_collect", 32'(sup_gnt), 0);
    cancel_in();
    wait_change(25, 3);
    idle(2);
    chk("t5_gnt_after_refund", 32'(sup_gnt), 1);
    sup_req = 1'b0;
    idle(2);

    // 6: reset discards credit, then exact-price vend with no change
    repeat (2) coin_in(2'd2);
    chk("t6_balance", 32'(balance), 50);
    c0 = chg_cnt;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t6_balance_rst", 32'(balance), 0);
    sel_in(COLA);
    chk("t6_idle_low_credit", 32'(status), 2);
    idle(2);
    chk("t6_no_change_rst", 32'(chg_cnt), 32'(c0));
    repeat (2) coin_in(2'd2);
    sel_in(COLA);
    wait_vend(COLA, 4);
    idle(3);
    chk("t6_no_change_exact", 32'(chg_cnt), 32'(c0));
    chk("t6_balance_end", 32'(balance), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
